// File: rtl/uart_cmd_decoder.sv
// Stopwatch command decoder fed by the UART RX FIFO: R/S/C pulses and "T"+MMSS presets.
// Optional macro CMD_ECHO_EN echoes every consumed byte into the TX FIFO.
module uart_cmd_decoder #(
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_empty,
    input  logic [7:0] rx_rdata,
    output logic       rx_pop,
    output logic       run_pulse,
    output logic       stop_pulse,
    output logic       clear_pulse,
    output logic       set_valid,
    output logic [5:0] set_min,
    output logic [5:0] set_sec,
    output logic       cmd_err,
    input  logic       tx_full,
    output logic       tx_push,
    output logic [7:0] tx_wdata
);

`ifdef CMD_ECHO_EN
    typedef enum logic [1:0] {IDLE, DECODE, ECHO_WAIT} state_t;
`else
    typedef enum logic [0:0] {IDLE, DECODE} state_t;
`endif

    localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

    state_t         state;
    logic [7:0]     byte_reg;
    logic           set_mode;
    logic [1:0]     digit_cnt;
    logic [3:0]     d0, d1, d2;
    logic [CW-1:0]  to_cnt;

    logic           is_digit;
    logic           is_blank;
    logic [3:0]     digit;
    logic [7:0]     upper;
    logic [6:0]     min_calc;
    logic [6:0]     sec_calc;

    // Clearing bit 5 folds lower-case letters onto upper case; blanks are tested on the raw byte.
    always_comb begin
        is_digit = (byte_reg >= 8'h30) && (byte_reg <= 8'h39);
        is_blank = (byte_reg == 8'h0D) || (byte_reg == 8'h0A) || (byte_reg == 8'h20);
        digit    = byte_reg[3:0];
        upper    = byte_reg & 8'hDF;
        min_calc = {3'b000, d0} * 7'd10 + {3'b000, d1};
        sec_calc = {3'b000, d2} * 7'd10 + {3'b000, digit};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            byte_reg    <= 8'h00;
            set_mode    <= 1'b0;
            digit_cnt   <= 2'd0;
            d0          <= 4'd0;
            d1          <= 4'd0;
            d2          <= 4'd0;
            to_cnt      <= '0;
            rx_pop      <= 1'b0;
            run_pulse   <= 1'b0;
            stop_pulse  <= 1'b0;
            clear_pulse <= 1'b0;
            set_valid   <= 1'b0;
            set_min     <= 6'd0;
            set_sec     <= 6'd0;
            cmd_err     <= 1'b0;
`ifdef CMD_ECHO_EN
            tx_push     <= 1'b0;
            tx_wdata    <= 8'h00;
`endif
        end else begin
            rx_pop      <= 1'b0;
            run_pulse   <= 1'b0;
            stop_pulse  <= 1'b0;
            clear_pulse <= 1'b0;
            set_valid   <= 1'b0;
            cmd_err     <= 1'b0;
`ifdef CMD_ECHO_EN
            tx_push     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!rx_empty) begin
                        byte_reg <= rx_rdata;
                        rx_pop   <= 1'b1;
                        state    <= DECODE;
                    end
                end
                DECODE: begin
                    // A decoded byte always restarts the inter-byte timer, even if it was about to expire.
                    to_cnt <= '0;
                    if (set_mode) begin
                        if (is_digit && digit_cnt == 2'd3) begin
                            if (min_calc <= 7'd59 && sec_calc <= 7'd59) begin
                                set_valid <= 1'b1;
                                set_min   <= min_calc[5:0];
                                set_sec   <= sec_calc[5:0];
                            end else begin
                                cmd_err <= 1'b1;
                            end
                            set_mode  <= 1'b0;
                            digit_cnt <= 2'd0;
                        end else if (is_digit) begin
                            case (digit_cnt)
                                2'd0:    d0 <= digit;
                                2'd1:    d1 <= digit;
                                default: d2 <= digit;
                            endcase
                            digit_cnt <= digit_cnt + 2'd1;
                        end else begin
                            cmd_err   <= 1'b1;
                            set_mode  <= 1'b0;
                            digit_cnt <= 2'd0;
                        end
                    end else if (!is_blank) begin
                        case (upper)
                            8'h52: run_pulse   <= 1'b1;
                            8'h53: stop_pulse  <= 1'b1;
                            8'h43: clear_pulse <= 1'b1;
                            8'h54: begin
                                set_mode  <= 1'b1;
                                digit_cnt <= 2'd0;
                            end
                            default: cmd_err <= 1'b1;
                        endcase
                    end
`ifdef CMD_ECHO_EN
                    if (!tx_full) begin
                        tx_push  <= 1'b1;
                        tx_wdata <= byte_reg;
                        state    <= IDLE;
                    end else begin
                        state    <= ECHO_WAIT;
                    end
`else
                    state <= IDLE;
`endif
                end
`ifdef CMD_ECHO_EN
                ECHO_WAIT: begin
                    if (!tx_full) begin
                        tx_push  <= 1'b1;
                        tx_wdata <= byte_reg;
                        state    <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase

            // The timer only advances while waiting for the next preset byte.
            if (set_mode && state == IDLE) begin
                if (to_cnt == TO_LAST) begin
                    cmd_err   <= 1'b1;
                    set_mode  <= 1'b0;
                    digit_cnt <= 2'd0;
                    to_cnt    <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

`ifndef CMD_ECHO_EN
    logic unused_tx_full;
    assign unused_tx_full = tx_full;
    assign tx_push        = 1'b0;
    assign tx_wdata       = 8'h00;
`endif

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Scoreboard bench for uart_cmd_decoder: a queue-backed RX FIFO model feeds bytes,
// expected pulses/echoes are queued as bytes are sent and retired as the DUT emits them.
module tb_uart_cmd_decoder;

    localparam int TO = 50;

    localparam logic [2:0] EV_RUN   = 3'd1;
    localparam logic [2:0] EV_STOP  = 3'd2;
    localparam logic [2:0] EV_CLEAR = 3'd3;
    localparam logic [2:0] EV_SET   = 3'd4;
    localparam logic [2:0] EV_ERR   = 3'd5;

    typedef struct packed {
        logic [2:0] kind;
        logic [5:0] mn;
        logic [5:0] sc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx_empty = 1'b1;
    logic [7:0] rx_rdata = 8'h00;
    logic       tx_full = 1'b0;
    logic       rx_pop, run_pulse, stop_pulse, clear_pulse, set_valid, cmd_err, tx_push;
    logic [5:0] set_min, set_sec;
    logic [7:0] tx_wdata;

    ev_t        exp_q[$];
    logic [7:0] rxq[$];
    logic [7:0] echo_q[$];

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int pushes = 0;
    int cyc = 0;
    int pop_cyc = 0;
    int evt_cyc = 0;

    uart_cmd_decoder #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_rdata(rx_rdata), .rx_pop(rx_pop),
        .run_pulse(run_pulse), .stop_pulse(stop_pulse), .clear_pulse(clear_pulse),
        .set_valid(set_valid), .set_min(set_min), .set_sec(set_sec), .cmd_err(cmd_err),
        .tx_full(tx_full), .tx_push(tx_push), .tx_wdata(tx_wdata)
    );

    always #5 clk = ~clk;

    // RX FIFO model: a pop seen at a rising edge removes the head byte.
    logic [7:0] popped;
    always @(posedge clk) begin
        if (rst && rx_pop) begin
            if (rxq.size() > 0) popped = rxq.pop_front();
            pops++;
            pop_cyc = cyc;
        end
        cyc++;
    end

    always @(negedge clk) begin
        rx_empty = (rxq.size() == 0);
        rx_rdata = rx_empty ? 8'h00 : rxq[0];
    end

    // Output monitor: retires expected events and echoes in order.
    int         hot;
    logic [2:0] kind;
    ev_t        e;
    logic [7:0] ew;
    always @(negedge clk) begin
        if (rst) begin
            hot = int'(run_pulse) + int'(stop_pulse) + int'(clear_pulse) + int'(set_valid) + int'(cmd_err);
            if (hot != 0) begin
                evt_cyc = cyc;
                checks++;
                if (hot > 1) begin
                    failures++;
                    $display("[TB] FAIL onehot: %0d result outputs high, required 1", hot);
                end
                kind = run_pulse ? EV_RUN : stop_pulse ? EV_STOP : clear_pulse ? EV_CLEAR :
                       set_valid ? EV_SET : EV_ERR;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_event: got kind %0d, none expected", kind);
                end else begin
                    e = exp_q.pop_front();
                    if (kind !== e.kind) begin
                        failures++;
                        $display("[TB] FAIL event_kind: got %0d, required %0d", kind, e.kind);
                    end
                    if (e.kind == EV_SET) begin
                        checks++;
                        if ({set_min, set_sec} !== {e.mn, e.sc}) begin
                            failures++;
                            $display("[TB] FAIL preset_value: got %0d:%0d, required %0d:%0d",
                                     set_min, set_sec, e.mn, e.sc);
                        end
                    end
                end
            end
            if (tx_push) begin
                pushes++;
                checks++;
`ifdef CMD_ECHO_EN
                if (echo_q.size() == 0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_echo: got 0x%02h, none expected", tx_wdata);
                end else begin
                    ew = echo_q.pop_front();
                    if (tx_wdata !== ew) begin
                        failures++;
                        $display("[TB] FAIL echo_data: got 0x%02h, required 0x%02h", tx_wdata, ew);
                    end
                end
`else
                failures++;
                $display("[TB] FAIL tx_push_tied: got tx_push=1, required 0");
`endif
            end
        end
    end

    task automatic applyStimulus(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rxq.push_back(s[i]);
`ifdef CMD_ECHO_EN
            echo_q.push_back(s[i]);
`endif
        end
    endtask

    task automatic expect_ev(input logic [2:0] k, input int mn = 0, input int sc = 0);
        ev_t n;
        n.kind = k;
        n.mn   = 6'(mn);
        n.sc   = 6'(sc);
        exp_q.push_back(n);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((rxq.size() != 0 || exp_q.size() != 0 || echo_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_timeout: %0d bytes / %0d events / %0d echoes left, required 0",
                     name, rxq.size(), exp_q.size(), echo_q.size());
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic check_zero_outputs(input string name);
        checks++;
        if ({rx_pop, run_pulse, stop_pulse, clear_pulse, set_valid, set_min, set_sec,
             cmd_err, tx_push, tx_wdata} !== 27'd0) begin
            failures++;
            $display("[TB] FAIL %s: outputs pop=%b pulses=%b%b%b%b%b min=%0d sec=%0d push=%b wdata=0x%02h, required all 0",
                     name, rx_pop, run_pulse, stop_pulse, clear_pulse, set_valid, cmd_err,
                     set_min, set_sec, tx_push, tx_wdata);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset_outputs");
        rst = 1'b1;
        @(negedge clk);
        check_zero_outputs("post_reset_outputs");
        pops = 0;
        applyStimulus("r");
        expect_ev(EV_RUN);
        wait_idle(100, "run");
        checks++;
        if (pops !== 1) begin
            failures++;
            $display("[TB] FAIL run_pops: got %0d, required 1", pops);
        end
        checks++;
        if (evt_cyc - pop_cyc !== 1) begin
            failures++;
            $display("[TB] FAIL run_latency: pulse %0d cycles after pop, required 1", evt_cyc - pop_cyc);
        end
    endtask

    task automatic test_preset();
        int p0 = pops;
        applyStimulus("T0930");
        expect_ev(EV_SET, 9, 30);
        wait_idle(200, "preset");
        checks++;
        if (pops - p0 !== 5) begin
            failures++;
            $display("[TB] FAIL preset_pops: got %0d, required 5", pops - p0);
        end
    endtask

    task automatic test_range();
        applyStimulus("T0975");
        expect_ev(EV_ERR);
        wait_idle(200, "range");
        checks++;
        if ({set_min, set_sec} !== {6'd9, 6'd30}) begin
            failures++;
            $display("[TB] FAIL range_hold: got %0d:%0d, required 9:30", set_min, set_sec);
        end
        applyStimulus("c");
        expect_ev(EV_CLEAR);
        wait_idle(100, "clear");
        applyStimulus("T5959");
        expect_ev(EV_SET, 59, 59);
        wait_idle(200, "max_preset");
        applyStimulus("T6000");
        expect_ev(EV_ERR);
        wait_idle(200, "min_range");
    endtask

    task automatic test_bad_digit_timeout();
        applyStimulus("T09x");
        expect_ev(EV_ERR);
        wait_idle(200, "bad_digit");
        applyStimulus("T12");
        expect_ev(EV_ERR);
        wait_idle(TO * 4, "timeout");
        checks++;
        if (evt_cyc - pop_cyc < TO - 2 || evt_cyc - pop_cyc > TO + 3) begin
            failures++;
            $display("[TB] FAIL timeout_delay: err %0d cycles after last pop, required about %0d",
                     evt_cyc - pop_cyc, TO);
        end
        applyStimulus("5");
        expect_ev(EV_ERR);
        wait_idle(100, "digit_after_timeout");
    endtask

    task automatic test_gap();
        applyStimulus("T12");
        wait_idle(100, "gap_head");
        repeat (TO / 3) @(negedge clk);
        applyStimulus("34");
        expect_ev(EV_SET, 12, 34);
        wait_idle(100, "gap_tail");
    endtask

    task automatic test_ignore();
        int p0 = pops;
        applyStimulus("s\r\nq");
        expect_ev(EV_STOP);
        expect_ev(EV_ERR);
        wait_idle(200, "ignore");
        checks++;
        if (pops - p0 !== 4) begin
            failures++;
            $display("[TB] FAIL ignore_pops: got %0d, required 4", pops - p0);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus("RSCrsc");
        expect_ev(EV_RUN);
        expect_ev(EV_STOP);
        expect_ev(EV_CLEAR);
        expect_ev(EV_RUN);
        expect_ev(EV_STOP);
        expect_ev(EV_CLEAR);
        wait_idle(200, "back_to_back");
    endtask

    task automatic test_reset_mid();
        applyStimulus("T1");
        wait_idle(100, "reset_mid_head");
        rst = 1'b0;
        @(negedge clk);
        check_zero_outputs("reset_mid_outputs");
        exp_q.delete();
        echo_q.delete();
        rst = 1'b1;
        @(negedge clk);
        applyStimulus("0");
        expect_ev(EV_ERR);
        wait_idle(100, "reset_mid_tail");
    endtask

`ifdef CMD_ECHO_EN
    task automatic test_echo();
        int p0 = pops;
        int e0;
        tx_full = 1'b1;
        e0 = pushes;
        applyStimulus("Cr");
        expect_ev(EV_CLEAR);
        repeat (20) @(negedge clk);
        checks++;
        if (pops - p0 !== 1 || exp_q.size() !== 0 || pushes !== e0) begin
            failures++;
            $display("[TB] FAIL echo_hold: pops %0d events_left %0d pushes %0d, required 1/0/0",
                     pops - p0, exp_q.size(), pushes - e0);
        end
        expect_ev(EV_RUN);
        tx_full = 1'b0;
        wait_idle(100, "echo_release");
        checks++;
        if (pops - p0 !== 2 || pushes - e0 !== 2) begin
            failures++;
            $display("[TB] FAIL echo_count: pops %0d pushes %0d, required 2/2", pops - p0, pushes - e0);
        end
    endtask
`endif

    task automatic checkOutput();
        checks++;
        if (exp_q.size() !== 0 || echo_q.size() !== 0) begin
            failures++;
            $display("[TB] FAIL leftovers: %0d events %0d echoes pending, required 0",
                     exp_q.size(), echo_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_preset();
        test_range();
        test_bad_digit_timeout();
        test_gap();
        test_ignore();
        test_back_to_back();
`ifdef CMD_ECHO_EN
        test_echo();
`endif
        test_reset_mid();
        checkOutput();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
